half_store_narrow: RTL and testbench

- Store-side narrowing unit for the single-cycle MIPS datapath; the inverse path of immediate sign extension.
- Takes 32-bit store requests (sh or sw) from the datapath.
- Emits them as one or two 16-bit beats on a valid/ready halfword memory bus.
- For sh, flags data that sign-extending the stored halfword cannot reproduce.

---
 rtl/half_store_narrow_if.sv | 26 ++
 rtl/half_store_narrow.sv | 110 +++++++++++
 tb/tb_half_store_narrow.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/half_store_narrow_if.sv
// rtl/half_store_narrow_if.sv - store request and halfword memory bus bundle
// The narrowing unit takes the slave view; the datapath/memory side takes the master view.
interface half_store_narrow_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_mode;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              ovf;

  modport slave (
    input  req_valid, req_mode, req_addr, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_data, ovf
  );

  modport master (
    output req_valid, req_mode, req_addr, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_data, ovf
  );
endinterface

// File: rtl/half_store_narrow.sv
// rtl/half_store_narrow.sv - splits sh/sw store requests into 16-bit memory beats
// sh yields one beat (with a sign-extension overflow flag), sw yields low then high beat.
module half_store_narrow #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  half_store_narrow_if.slave  bus,
  output logic                align_err,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_mode;
  logic [15:0]       r_data_hi;
  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_data;
  logic              r_ovf;
  logic              r_align_err;

  logic w_final;
  logic w_req_ready;
  logic w_accept;
  logic w_misaligned;
  logic w_ovf;

  // The last beat of a request may hand over to the next request on the same edge.
  assign w_final      = ((r_state == LO) && !r_mode) || (r_state == HI);
  assign w_req_ready  = !reset && ((r_state == IDLE) || (w_final && bus.mem_ready));
  assign w_accept     = bus.req_valid && w_req_ready;
  assign w_misaligned = bus.req_mode ? (bus.req_addr[1:0] != 2'b00) : bus.req_addr[0];
  assign w_ovf        = !bus.req_mode && (bus.req_data[31:16] != {16{bus.req_data[15]}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mode      <= 1'b0;
      r_data_hi   <= 16'h0000;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= 16'h0000;
      r_ovf       <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= 1'b0;
      if (w_accept) begin
        if (w_misaligned) begin
          // Dropped request: address/data registers keep their last beat.
          r_state     <= IDLE;
          r_mem_valid <= 1'b0;
          r_ovf       <= 1'b0;
          r_align_err <= 1'b1;
        end else begin
          r_state     <= LO;
          r_mode      <= bus.req_mode;
          r_data_hi   <= bus.req_data[31:16];
          r_mem_valid <= 1'b1;
          r_mem_addr  <= {bus.req_addr[ADDR_W-1:1], 1'b0};
          r_mem_data  <= bus.req_data[15:0];
          r_ovf       <= w_ovf;
        end
      end else begin
        case (r_state)
          LO: begin
            if (bus.mem_ready) begin
              if (r_mode) begin
                r_state    <= HI;
                r_mem_addr <= r_mem_addr + ADDR_W'(2);
                r_mem_data <= r_data_hi;
                r_ovf      <= 1'b0;
              end else begin
                r_state     <= IDLE;
                r_mem_valid <= 1'b0;
                r_ovf       <= 1'b0;
              end
            end
          end
          HI: begin
            if (bus.mem_ready) begin
              r_state     <= IDLE;
              r_mem_valid <= 1'b0;
              r_ovf       <= 1'b0;
            end
          end
          default: begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
            r_ovf       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_data  = r_mem_data;
  assign bus.ovf       = r_ovf;
  assign align_err     = r_align_err;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_half_store_narrow.sv
// tb/tb_half_store_narrow.sv - randomized and directed bench for half_store_narrow
// A queue of outstanding beats models the unit; an 8-bit-address instance covers the wrap case.
module tb_half_store_narrow;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic align_err, busy, align_err8, busy8;

  half_store_narrow_if #(.ADDR_W(32)) bus  ();
  half_store_narrow_if #(.ADDR_W(8))  bus8 ();

  half_store_narrow #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .align_err(align_err), .busy(busy)
  );
  half_store_narrow #(.ADDR_W(8)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8), .align_err(align_err8), .busy(busy8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    logic        ovf;
  } beat_t;

  beat_t       exp_q[$];
  logic        exp_align = 1'b0;
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          hs_count  = 0;
  logic        obs_valid, obs_ovf, obs_align;
  logic [31:0] obs_addr;
  logic [15:0] obs_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock of the 32-bit unit: check outputs against the model, apply inputs, advance the model.
  task automatic cycle(input logic v, input logic m, input logic [31:0] a,
                       input logic [31:0] d, input logic mr);
    logic exp_ready;
    int   sd;
    @(negedge clk);
    obs_valid = bus.mem_valid;
    obs_addr  = bus.mem_addr;
    obs_data  = bus.mem_data;
    obs_ovf   = bus.ovf;
    obs_align = align_err;
    if (exp_q.size() != 0) begin
      check("mem_valid", bus.mem_valid, 1);
      check("mem_addr", bus.mem_addr, exp_q[0].addr);
      check("mem_data", bus.mem_data, exp_q[0].data);
      check("ovf", bus.ovf, exp_q[0].ovf);
    end else begin
      check("mem_valid_idle", bus.mem_valid, 0);
      check("ovf_idle", bus.ovf, 0);
    end
    check("align_err", align_err, exp_align);
    check("busy", busy, exp_q.size() != 0);
    bus.req_valid = v;
    bus.req_mode  = m;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.mem_ready = mr;
    #1;
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && mr);
    check("req_ready", bus.req_ready, exp_ready);
    if (exp_q.size() != 0 && mr) begin
      void'(exp_q.pop_front());
      hs_count++;
    end
    exp_align = 1'b0;
    if (v && exp_ready) begin
      if (m ? (a % 4 != 0) : (a % 2 != 0)) begin
        exp_align = 1'b1;
      end else begin
        sd = $signed(d);
        exp_q.push_back('{addr: a & ~32'h1, data: d[15:0],
                          ovf: !m && (sd < -32768 || sd > 32767)});
        if (m) exp_q.push_back('{addr: a + 32'd2, data: d[31:16], ovf: 1'b0});
      end
    end
  endtask

  task automatic idle(input logic mr);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, mr);
  endtask

  initial begin
    int          hs0;
    logic [31:0] ra, rd;
    bus.req_valid  = 1'b0; bus.req_mode  = 1'b0; bus.req_addr  = '0; bus.req_data  = '0;
    bus.mem_ready  = 1'b1;
    bus8.req_valid = 1'b0; bus8.req_mode = 1'b0; bus8.req_addr = '0; bus8.req_data = '0;
    bus8.mem_ready = 1'b1;

    // Reset state, including req_ready held low while reset is high.
    repeat (2) @(negedge clk);
    bus.req_valid = 1'b1;
    #1;
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_align_err", align_err, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b0;

    // sh aligned, no stall.
    cycle(1'b1, 1'b0, 32'h100, 32'hFFFF8001, 1'b1);
    idle(1'b1);
    check("sh_addr", obs_addr, 32'h100);
    check("sh_data", obs_data, 16'h8001);
    check("sh_ovf", obs_ovf, 0);
    idle(1'b1);
    check("sh_done", obs_valid, 0);

    // sh overflow and in-range boundary.
    cycle(1'b1, 1'b0, 32'h102, 32'h00018000, 1'b1);
    cycle(1'b1, 1'b0, 32'h104, 32'h00007FFF, 1'b1);
    check("ovf_data", obs_data, 16'h8000);
    check("ovf_set", obs_ovf, 1);
    idle(1'b1);
    check("ovf_clear", obs_ovf, 0);
    check("ovf_clear_addr", obs_addr, 32'h104);
    idle(1'b1);

    // sw with three-cycle stall on each beat.
    hs0 = hs_count;
    cycle(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b1);
    check("sw_lo_addr", obs_addr, 32'h200);
    check("sw_lo_data", obs_data, 16'hBEEF);
    idle(1'b0); idle(1'b0); idle(1'b1);
    check("sw_hi_addr", obs_addr, 32'h202);
    check("sw_hi_data", obs_data, 16'hDEAD);
    idle(1'b1);
    check("sw_handshakes", hs_count - hs0, 2);

    // Back-to-back sw then sh with req_valid held.
    cycle(1'b1, 1'b1, 32'h10, 32'h11112222, 1'b1);
    cycle(1'b1, 1'b0, 32'h20, 32'h00003333, 1'b1);
    check("b2b_0", {obs_valid, obs_addr, obs_data}, {1'b1, 32'h10, 16'h2222});
    cycle(1'b1, 1'b0, 32'h20, 32'h00003333, 1'b1);
    check("b2b_1", {obs_valid, obs_addr, obs_data}, {1'b1, 32'h12, 16'h1111});
    idle(1'b1);
    check("b2b_2", {obs_valid, obs_addr, obs_data}, {1'b1, 32'h20, 16'h3333});
    idle(1'b1);

    // Misaligned sh and sw, then top-of-space sw.
    cycle(1'b1, 1'b0, 32'h101, 32'h1, 1'b1);
    idle(1'b1);
    check("mis_sh_pulse", {obs_align, obs_valid}, 2'b10);
    cycle(1'b1, 1'b1, 32'h102, 32'h1, 1'b1);
    check("mis_sh_end", obs_align, 0);
    idle(1'b1);
    check("mis_sw_pulse", {obs_align, obs_valid}, 2'b10);
    cycle(1'b1, 1'b1, 32'hFFFFFFFC, 32'h89ABCDEF, 1'b1);
    idle(1'b1); idle(1'b1);
    check("top_hi_addr", obs_addr, 32'hFFFFFFFE);
    idle(1'b1);

    // Reset while the high beat of a sw is stalled.
    cycle(1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 1'b1);
    idle(1'b1);
    idle(1'b0);
    check("mid_hi_addr", obs_addr, 32'h302);
    bus.req_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("arst_mem_valid", bus.mem_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_req_ready", bus.req_ready, 0);
    exp_q.delete();
    exp_align = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    cycle(1'b1, 1'b0, 32'h400, 32'h00001234, 1'b1);
    idle(1'b1);
    check("post_rst_addr", obs_addr, 32'h400);
    idle(1'b1);
    check("no_stray_hi", obs_valid, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      if ($urandom_range(3) != 0) ra[1:0] = ($urandom_range(1) != 0) ? 2'b00 : 2'b10;
      rd = $urandom;
      if ($urandom_range(1) != 0) rd[31:16] = {16{rd[15]}};
      cycle($urandom_range(1) != 0, $urandom_range(1) != 0, ra, rd, $urandom_range(9) < 7);
    end
    idle(1'b1); idle(1'b1); idle(1'b1);

    // 8-bit address instance: top-of-space sw and misaligned sw.
    @(negedge clk);
    bus8.req_valid = 1'b1; bus8.req_mode = 1'b1;
    bus8.req_addr = 8'hFC; bus8.req_data = 32'hA5A55A5A; bus8.mem_ready = 1'b1;
    @(negedge clk);
    bus8.req_valid = 1'b0;
    check("w8_lo", {bus8.mem_valid, bus8.mem_addr, bus8.mem_data}, {1'b1, 8'hFC, 16'h5A5A});
    @(negedge clk);
    check("w8_hi", {bus8.mem_valid, bus8.mem_addr, bus8.mem_data}, {1'b1, 8'hFE, 16'hA5A5});
    @(negedge clk);
    check("w8_done", {bus8.mem_valid, busy8}, 2'b00);
    bus8.req_valid = 1'b1; bus8.req_addr = 8'hFE;
    @(negedge clk);
    bus8.req_valid = 1'b0;
    check("w8_mis", {align_err8, bus8.mem_valid}, 2'b10);
    @(negedge clk);
    check("w8_mis_end", align_err8, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
